// File: rtl/checkboard_cursor_ctrl_if.sv
// rtl/checkboard_cursor_ctrl_if.sv - Button/vsync inputs and marked-block outputs of the cursor controller
//
// Purpose: bundles everything the cursor controller exchanges with the board
// and the VGA/checkboard pipeline, apart from the clock and reset.
// Ports (signals):
//   iBtnUp/iBtnDown/iBtnLeft/iBtnRight : raw asynchronous push-buttons, active-high
//   iVGAVerticalSync                   : active-low vertical sync, Clock domain
//   oMarkedBlockPosX/oMarkedBlockPosY  : committed cursor column/row
//   oMoveEvent                         : one-cycle pulse per internal cursor move
// Modports: master = board/pipeline side, slave = cursor controller.
interface checkboard_cursor_ctrl_if;
  logic       iBtnUp;
  logic       iBtnDown;
  logic       iBtnLeft;
  logic       iBtnRight;
  logic       iVGAVerticalSync;
  logic [2:0] oMarkedBlockPosX;
  logic [2:0] oMarkedBlockPosY;
  logic       oMoveEvent;

  modport master (
    output iBtnUp, iBtnDown, iBtnLeft, iBtnRight, iVGAVerticalSync,
    input  oMarkedBlockPosX, oMarkedBlockPosY, oMoveEvent
  );

  modport slave (
    input  iBtnUp, iBtnDown, iBtnLeft, iBtnRight, iVGAVerticalSync,
    output oMarkedBlockPosX, oMarkedBlockPosY, oMoveEvent
  );
endinterface

// File: rtl/checkboard_cursor_ctrl.sv
// rtl/checkboard_cursor_ctrl.sv - Debounced push-button cursor with auto-repeat and vsync-aligned commit
//
// Purpose: synchronises, debounces and edge-detects four buttons, moves a
// wrap-around cursor on the block grid (with auto-repeat while held) and
// commits the position to the outputs only at the vsync falling edge.
// Ports:
//   Clock : single rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : checkboard_cursor_ctrl_if.slave (buttons, vsync, position, move pulse)
module checkboard_cursor_ctrl #(
  parameter int          GRID_X          = 4,
  parameter int          GRID_Y          = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd1250000
) (
  input logic                     Clock,
  input logic                     Reset,
  checkboard_cursor_ctrl_if.slave bus
);
  localparam logic [2:0] MaxX     = 3'(GRID_X - 1);
  localparam logic [2:0] MaxY     = 3'(GRID_Y - 1);
  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} repeatStateT;

  logic [3:0]  btnRaw;
  logic [3:0]  sync1, sync2, stable, stablePrev, armed, pressEdge;
  logic [15:0] dbCnt [4];
  logic [1:0]  syncValid;

  repeatStateT state, stateNext;
  logic [23:0] rptCnt, rptCntNext;
  logic [1:0]  dir, dirNext, pressDir, moveDir;
  logic        doMove;

  logic [2:0]  posX, posY, markX, markY;
  logic        moveEvent, vsyncPrev;

  assign btnRaw = {bus.iBtnRight, bus.iBtnLeft, bus.iBtnDown, bus.iBtnUp};

  // A button only produces press edges once it has been seen released after
  // reset. syncValid marks when sync2 reflects the real pin rather than its
  // reset value, so a button held through reset stays unarmed until let go.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      stablePrev <= '0;
      armed      <= '0;
      syncValid  <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      sync1      <= btnRaw;
      sync2      <= sync1;
      stablePrev <= stable;
      syncValid  <= {syncValid[0], 1'b1};
      for (int i = 0; i < 4; i++) begin
        if (syncValid[1] && !sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] == stable[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          stable[i] <= ~stable[i];
          dbCnt[i]  <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 16'd1;
        end
      end
    end
  end

  assign pressEdge = stable & ~stablePrev & armed;

  // Up > Down > Left > Right
  always_comb begin
    pressDir = DirRight;
    if (pressEdge[0])      pressDir = DirUp;
    else if (pressEdge[1]) pressDir = DirDown;
    else if (pressEdge[2]) pressDir = DirLeft;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      rptCnt <= '0;
      dir    <= DirUp;
    end else begin
      state  <= stateNext;
      rptCnt <= rptCntNext;
      dir    <= dirNext;
    end
  end

  always_comb begin
    stateNext  = state;
    rptCntNext = rptCnt;
    dirNext    = dir;
    doMove     = 1'b0;
    moveDir    = dir;
    case (state)
      IDLE: begin
        if (|pressEdge) begin
          doMove     = 1'b1;
          moveDir    = pressDir;
          dirNext    = pressDir;
          rptCntNext = '0;
          stateNext  = DELAY;
        end
      end
      DELAY: begin
        // With REPEAT_DELAY == 0 the FSM parks here until release.
        if (!stable[dir]) begin
          stateNext = IDLE;
        end else if ((REPEAT_DELAY != 24'd0) && (rptCnt == REPEAT_DELAY - 24'd1)) begin
          doMove     = 1'b1;
          rptCntNext = '0;
          stateNext  = REPEAT;
        end else begin
          rptCntNext = rptCnt + 24'd1;
        end
      end
      REPEAT: begin
        if (!stable[dir]) begin
          stateNext = IDLE;
        end else if (rptCnt == REPEAT_RATE - 24'd1) begin
          doMove     = 1'b1;
          rptCntNext = '0;
        end else begin
          rptCntNext = rptCnt + 24'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The commit samples the pre-move position when both happen on one edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      posX      <= '0;
      posY      <= '0;
      markX     <= '0;
      markY     <= '0;
      moveEvent <= 1'b0;
      vsyncPrev <= 1'b1;
    end else begin
      moveEvent <= doMove;
      vsyncPrev <= bus.iVGAVerticalSync;
      if (vsyncPrev && !bus.iVGAVerticalSync) begin
        markX <= posX;
        markY <= posY;
      end
      if (doMove) begin
        case (moveDir)
          DirUp:    posY <= (posY == 3'd0) ? MaxY : posY - 3'd1;
          DirDown:  posY <= (posY == MaxY) ? 3'd0 : posY + 3'd1;
          DirLeft:  posX <= (posX == 3'd0) ? MaxX : posX - 3'd1;
          default:  posX <= (posX == MaxX) ? 3'd0 : posX + 3'd1;
        endcase
      end
    end
  end

  assign bus.oMarkedBlockPosX = markX;
  assign bus.oMarkedBlockPosY = markY;
  assign bus.oMoveEvent       = moveEvent;
endmodule

// File: tb/tb_checkboard_cursor_ctrl.sv
// tb/tb_checkboard_cursor_ctrl.sv - Directed self-checking bench for checkboard_cursor_ctrl
module tb_checkboard_cursor_ctrl;
  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] DOWN  = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0100;
  localparam logic [3:0] RIGHT = 4'b1000;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   cyc  = 0;
  int   errors = 0;
  int   checks = 0;
  int   moveCycles[$];

  checkboard_cursor_ctrl_if bus();

  checkboard_cursor_ctrl #(
    .GRID_X(4), .GRID_Y(4), .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY(24'd8), .REPEAT_RATE(24'd4)
  ) dut (
    .Clock(clk),
    .Reset(rstN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge index of every move pulse.
  always @(posedge clk) begin
    #1;
    if (bus.oMoveEvent === 1'b1) moveCycles.push_back(cyc);
  end

  // vsync low for 2 of every 20 cycles
  initial begin
    bus.iVGAVerticalSync = 1'b1;
    forever begin
      @(negedge clk);
      bus.iVGAVerticalSync = ((cyc % 20) >= 18) ? 1'b0 : 1'b1;
    end
  end

  task automatic setBtns(input logic [3:0] m);
    bus.iBtnUp    = m[0];
    bus.iBtnDown  = m[1];
    bus.iBtnLeft  = m[2];
    bus.iBtnRight = m[3];
  endtask

  // Raw level first sampled at edge kEdge, held for hold edges.
  task automatic pressRelease(input logic [3:0] m, input int hold, output int kEdge);
    @(negedge clk);
    setBtns(m);
    kEdge = cyc + 1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    setBtns(4'b0);
    repeat (14) @(posedge clk);
  endtask

  task automatic waitCommit();
    repeat (45) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    setBtns(4'b0);
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", bus.oMarkedBlockPosX); end
    checks++; if (bus.oMarkedBlockPosY !== 3'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", bus.oMarkedBlockPosY); end
    checks++; if (bus.oMoveEvent !== 1'b0) begin errors++; $display("FAIL reset_evt: got %0b expected 0", bus.oMoveEvent); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_press_right();
    int k;
    moveCycles.delete();
    @(negedge clk);
    setBtns(RIGHT);
    k = cyc + 1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bus.oMoveEvent !== 1'b0) begin errors++; $display("FAIL right_early: got %0b expected 0 at edge %0d", bus.oMoveEvent, cyc); end
    @(posedge clk);
    #1;
    checks++; if (bus.oMoveEvent !== 1'b1) begin errors++; $display("FAIL right_latency: got %0b expected 1 at edge k+6", bus.oMoveEvent); end
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL right_precommit_x: got %0d expected 0", bus.oMarkedBlockPosX); end
    @(negedge clk);
    setBtns(4'b0);
    repeat (14) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 1) begin errors++; $display("FAIL right_count: got %0d expected 1", moveCycles.size()); end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosX !== 3'd1) begin errors++; $display("FAIL right_x: got %0d expected 1", bus.oMarkedBlockPosX); end
    checks++; if (bus.oMarkedBlockPosY !== 3'd0) begin errors++; $display("FAIL right_y: got %0d expected 0", bus.oMarkedBlockPosY); end
  endtask

  task automatic test_wrap();
    int k;
    moveCycles.delete();
    pressRelease(RIGHT, 6, k);
    pressRelease(RIGHT, 6, k);
    waitCommit();
    checks++; if (bus.oMarkedBlockPosX !== 3'd3) begin errors++; $display("FAIL wrap_x3: got %0d expected 3", bus.oMarkedBlockPosX); end
    pressRelease(RIGHT, 6, k);
    waitCommit();
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL wrap_x0: got %0d expected 0", bus.oMarkedBlockPosX); end
    checks++; if (moveCycles.size() !== 3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", moveCycles.size()); end
    pressRelease(UP, 6, k);
    waitCommit();
    checks++; if (bus.oMarkedBlockPosY !== 3'd3) begin errors++; $display("FAIL wrap_y3: got %0d expected 3", bus.oMarkedBlockPosY); end
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL wrap_up_x: got %0d expected 0", bus.oMarkedBlockPosX); end
  endtask

  task automatic test_bounce();
    moveCycles.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      setBtns((i % 2 == 0) ? DOWN : 4'b0);
    end
    @(negedge clk);
    setBtns(4'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 0) begin errors++; $display("FAIL bounce_count: got %0d expected 0", moveCycles.size()); end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosY !== 3'd3) begin errors++; $display("FAIL bounce_y: got %0d expected 3", bus.oMarkedBlockPosY); end
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL bounce_x: got %0d expected 0", bus.oMarkedBlockPosX); end
  endtask

  task automatic test_hold_left();
    int k;
    int t0;
    int offs[7];
    offs = '{0, 8, 12, 16, 20, 24, 28};
    moveCycles.delete();
    @(negedge clk);
    setBtns(LEFT);
    k  = cyc + 1;
    t0 = k + 6;
    repeat (t0 + 24 - cyc) @(posedge clk);
    @(negedge clk);
    setBtns(4'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 7) begin errors++; $display("FAIL hold_count: got %0d expected 7", moveCycles.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < moveCycles.size()) begin
        checks++; if (moveCycles[i] - t0 !== offs[i]) begin errors++; $display("FAIL hold_time%0d: got t0+%0d expected t0+%0d", i, moveCycles[i] - t0, offs[i]); end
      end
    end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosX !== 3'd1) begin errors++; $display("FAIL hold_x: got %0d expected 1", bus.oMarkedBlockPosX); end
    checks++; if (moveCycles.size() !== 7) begin errors++; $display("FAIL hold_stop: got %0d expected 7", moveCycles.size()); end
    pressRelease(LEFT, 6, k);
    waitCommit();
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL hold_repress_x: got %0d expected 0", bus.oMarkedBlockPosX); end
  endtask

  task automatic test_simultaneous();
    int k;
    moveCycles.delete();
    @(negedge clk);
    setBtns(UP | RIGHT);
    k = cyc + 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    setBtns(RIGHT);
    repeat (30) @(posedge clk);
    @(negedge clk);
    setBtns(4'b0);
    repeat (14) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 1) begin errors++; $display("FAIL simul_count: got %0d expected 1", moveCycles.size()); end
    if (moveCycles.size() > 0) begin
      checks++; if (moveCycles[0] !== k + 6) begin errors++; $display("FAIL simul_time: got %0d expected %0d", moveCycles[0], k + 6); end
    end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosY !== 3'd2) begin errors++; $display("FAIL simul_y: got %0d expected 2", bus.oMarkedBlockPosY); end
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL simul_x: got %0d expected 0", bus.oMarkedBlockPosX); end
  endtask

  task automatic test_reset_mid_repeat();
    int k;
    @(negedge clk);
    setBtns(DOWN);
    k = cyc + 1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    moveCycles.delete();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.oMarkedBlockPosX !== 3'd0) begin errors++; $display("FAIL rst_mid_x: got %0d expected 0", bus.oMarkedBlockPosX); end
    checks++; if (bus.oMarkedBlockPosY !== 3'd0) begin errors++; $display("FAIL rst_mid_y: got %0d expected 0", bus.oMarkedBlockPosY); end
    checks++; if (bus.oMoveEvent !== 1'b0) begin errors++; $display("FAIL rst_mid_evt: got %0b expected 0", bus.oMoveEvent); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 0) begin errors++; $display("FAIL rst_held_count: got %0d expected 0", moveCycles.size()); end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosY !== 3'd0) begin errors++; $display("FAIL rst_held_y: got %0d expected 0", bus.oMarkedBlockPosY); end
    @(negedge clk);
    setBtns(4'b0);
    repeat (14) @(posedge clk);
    #1;
    checks++; if (moveCycles.size() !== 0) begin errors++; $display("FAIL rst_release_count: got %0d expected 0", moveCycles.size()); end
    pressRelease(DOWN, 6, k);
    checks++; if (moveCycles.size() !== 1) begin errors++; $display("FAIL rst_repress_count: got %0d expected 1", moveCycles.size()); end
    waitCommit();
    checks++; if (bus.oMarkedBlockPosY !== 3'd1) begin errors++; $display("FAIL rst_repress_y: got %0d expected 1", bus.oMarkedBlockPosY); end
  endtask

  initial begin
    setBtns(4'b0);
    test_reset();
    test_press_right();
    test_wrap();
    test_bounce();
    test_hold_left();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
